// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
// Optional addi support is enabled by defining MC_ADDI_EN.
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_EXECUTE   = 4'd6;
  localparam logic [3:0] ST_R_WB      = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_JUMP      = 4'd9;
  localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
  localparam logic [3:0] ST_ADDI_WB   = 4'd11;
  localparam logic [3:0] ST_ILLEGAL   = 4'd14;
  localparam logic [3:0] ST_RST_WAIT  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // First execution state for a decoded opcode; unknown opcodes trap.
  function automatic logic [3:0] dispatch_state(input logic [5:0] op);
    logic [3:0] st;
    case (op)
      OP_RTYPE:     st = ST_EXECUTE;
      OP_LW, OP_SW: st = ST_MEM_ADDR;
      OP_BEQ:       st = ST_BRANCH;
      OP_J:         st = ST_JUMP;
`ifdef MC_ADDI_EN
      OP_ADDI:      st = ST_ADDI_EXEC;
`endif
      default:      st = ST_ILLEGAL;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-vector decode for mc_main_control.
// ADDI states decode only when MC_ADDI_EN is defined.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALUOP_ADD;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only advance on the cycle the instruction word arrives.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MC_ADDI_EN
      ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      ST_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/write-back.
// Define MC_ADDI_EN to add the addi instruction (states ADDI_EXEC, ADDI_WB).
module mc_main_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp_out,
  output logic [3:0] state_out,
  output logic       illegal_op
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST_WAIT:  state_d = ST_FETCH;
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:    state_d = dispatch_state(Opcode);
      // Only lw/sw reach MEM_ADDR, so a single compare selects the path.
      ST_MEM_ADDR:  state_d = (Opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECUTE:   state_d = ST_R_WB;
      ST_MEM_WB,
      ST_R_WB,
      ST_BRANCH,
      ST_JUMP:      state_d = ST_FETCH;
`ifdef MC_ADDI_EN
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = ST_FETCH;
`endif
      ST_ILLEGAL:   state_d = ST_ILLEGAL;
      default:      state_d = ST_ILLEGAL;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp_out   = ctrl.alu_op;
  assign illegal_op  = ctrl.illegal_op;
  assign state_out   = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: instruction-level model plus directed sequences.
module tb_mc_main_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
  } outs_t;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp_out;
  logic [3:0] state_out;
  outs_t      dut_o;

  int checks = 0;
  int errors = 0;

  mc_main_control dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp_out   (ALUOp_out),
    .state_out   (state_out),
    .illegal_op  (illegal_op)
  );

  assign dut_o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp_out, illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: after decode, an instruction is a plan of remaining states; memory states stall.
  int m_state = 15;
  int plan[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 15;
      plan.delete();
    end else if (m_state == 15) begin
      m_state = 0;
    end else if (m_state == 14) begin
      m_state = 14;
    end else if (m_state == 0) begin
      if (mem_ready) m_state = 1;
    end else if (m_state == 1) begin
      case (Opcode)
        6'b000000: plan = '{6, 7};
        6'b100011: plan = '{2, 3, 4};
        6'b101011: plan = '{2, 5};
        6'b000100: plan = '{8};
        6'b000010: plan = '{9};
`ifdef MC_ADDI_EN
        6'b001000: plan = '{10, 11};
`endif
        default:   plan = '{14};
      endcase
      m_state = plan.pop_front();
    end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
      m_state = m_state;
    end else begin
      m_state = (plan.size() != 0) ? plan.pop_front() : 0;
    end
  end

  function automatic outs_t exp_outs(input int st, input logic mr);
    outs_t o;
    o = '0;
    case (st)
      0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      1: o.alu_src_b = 2'b11;
      2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3: begin o.mem_read = 1; o.iord = 1; end
      4: begin o.reg_write = 1; o.mem_to_reg = 1; end
      5: begin o.mem_write = 1; o.iord = 1; end
      6: begin o.alu_src_a = 1; o.alu_op = 3'b010; end
      7: begin o.reg_write = 1; o.reg_dst = 1; end
      8: begin o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      9: begin o.pc_write = 1; o.pc_source = 2'b10; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      11: o.reg_write = 1;
      14: o.illegal = 1;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    outs_t e;
    e = exp_outs(m_state, mem_ready);
    checks++;
    if (dut_o !== e || state_out !== m_state[3:0]) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t state got %h want %h outs got %h want %h",
               $time, state_out, m_state[3:0], dut_o, e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  int    exp_q[$];
  bit    mr_q[$];
  outs_t snap[16];

  // Walks one instruction from FETCH: checks each cycle's state and records the outputs.
  task automatic run_seq(input string name, input logic [5:0] op);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      snap[k] = dut_o;
      chk($sformatf("%s_st%0d", name, k), 32'(state_out), 32'(exp_q[k]));
      #1;
      Opcode    = op;
      mem_ready = mr_q[k];
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk({name, "_st"}, 32'(state_out), 32'hF);
    chk({name, "_outs"}, 32'(dut_o), 32'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    Opcode    = 6'b000000;
    mem_ready = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state_out), 32'hF);
    chk("rst_outs", 32'(dut_o), 32'h0);
    #1 reset = 1'b0;

    // R-type right after reset: F -> 0 -> 1 -> 6 -> 7.
    exp_q = '{0, 1, 6, 7};
    mr_q  = '{1, 1, 1, 1};
    run_seq("rtype", 6'b000000);
    chk("fetch_memread", 32'(snap[0].mem_read), 32'd1);
    chk("fetch_irwrite", 32'(snap[0].ir_write), 32'd1);
    chk("fetch_pcwrite", 32'(snap[0].pc_write), 32'd1);
    chk("fetch_srcb", 32'(snap[0].alu_src_b), 32'd1);
    chk("fetch_aluop", 32'(snap[0].alu_op), 32'd0);
    chk("exec_aluop", 32'(snap[2].alu_op), 32'd2);
    chk("rwb_regwrite", 32'(snap[3].reg_write), 32'd1);
    chk("rwb_regdst", 32'(snap[3].reg_dst), 32'd1);

    // lw with two stall cycles in MEM_READ; mem_ready low in DECODE/MEM_ADDR is ignored.
    exp_q = '{0, 1, 2, 3, 3, 3, 4};
    mr_q  = '{1, 0, 0, 0, 0, 1, 0};
    run_seq("lw", 6'b100011);
    chk("lw_memtoreg", 32'(snap[6].mem_to_reg), 32'd1);
    chk("lw_regwrite", 32'(snap[6].reg_write), 32'd1);

    // sw with one FETCH stall; the FETCH of this run sees mem_ready low.
    exp_q = '{0, 0, 1, 2, 5};
    mr_q  = '{0, 1, 1, 1, 1};
    run_seq("sw", 6'b101011);
    chk("sw_stall_irwrite", 32'(snap[0].ir_write), 32'd0);
    chk("sw_memwrite", 32'(snap[4].mem_write), 32'd1);

    exp_q = '{0, 1, 8};
    mr_q  = '{1, 1, 1};
    run_seq("beq", 6'b000100);
    chk("beq_aluop", 32'(snap[2].alu_op), 32'd1);
    chk("beq_pcwc", 32'(snap[2].pc_write_cond), 32'd1);
    chk("beq_pcsrc", 32'(snap[2].pc_source), 32'd1);

    exp_q = '{0, 1, 9};
    mr_q  = '{1, 1, 1};
    run_seq("j", 6'b000010);
    chk("j_pcwrite", 32'(snap[2].pc_write), 32'd1);
    chk("j_pcsrc", 32'(snap[2].pc_source), 32'd2);

`ifdef MC_ADDI_EN
    exp_q = '{0, 1, 10, 11};
    mr_q  = '{1, 1, 1, 1};
    run_seq("addi", 6'b001000);
    chk("addi_regwrite", 32'(snap[3].reg_write), 32'd1);
    chk("addi_regdst", 32'(snap[3].reg_dst), 32'd0);
`else
    exp_q = '{0, 1, 14};
    mr_q  = '{1, 1, 1};
    run_seq("addi", 6'b001000);
    chk("addi_illegal", 32'(snap[2].illegal), 32'd1);
`endif
    do_reset("addi_rst");

    // Illegal opcode is sticky until reset.
    exp_q = '{0, 1, 14};
    mr_q  = '{1, 1, 1};
    run_seq("ill", 6'b111111);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("ill_hold%0d", i), 32'({state_out, illegal_op}), 32'h1D);
      #1 mem_ready = (i % 2) != 0;
    end
    do_reset("ill_rst");

    // Reset asserted mid-MEM_WRITE must kill MemWrite immediately.
    exp_q = '{0, 1, 2};
    mr_q  = '{1, 1, 1};
    run_seq("swr", 6'b101011);
    @(negedge clk);
    chk("swr_in_write", 32'({state_out, MemWrite}), 32'hB);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("swr_memwrite", 32'(MemWrite), 32'd0);
    chk("swr_state", 32'(state_out), 32'hF);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle MIPS main control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back.
- Drives the datapath mux and enable lines, and generates the 3-bit ALUOp code consumed by the ALU control block, i.e. the initiator side of the ALUOp interface.
- Sits between the instruction register (opcode source) and the datapath/memory.
- Supported instructions: R-type, lw, sw, beq, j; optionally addi.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  6  IR[31:26]; stable outside FETCH because IR only loads in FETCH.
- mem_ready  in  1  memory handshake; the current access completes in a cycle where it is 1.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- PCSource  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp_out  out  3  000 = ADD, 001 = SUB, 010 = RTYPE (decode funct).
- state_out  out  4  current state encoding, for debug.
- illegal_op  out  1  high while in ILLEGAL.

Behaviour:
- Reset and output model:
  - Async reset forces state to RST_WAIT (4'hF).
  - All outputs are 0 in RST_WAIT, including ALUOp_out = 000.
  - After reset deasserts, the next clock edge moves RST_WAIT -> FETCH.
  - Outputs are a pure decode of state (plus mem_ready gating in FETCH only). Any output not listed for a state is 0; ALUOp_out defaults to ADD.
- FETCH (0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1):
  - ALUSrcA=0, ALUSrcB=11, ALUOp=ADD.
  - Next state by opcode:
    - 000000 -> EXECUTE
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC (only when the feature is enabled)
    - anything else -> ILLEGAL
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ (3): MemRead=1, IorD=1. Waits for mem_ready, then -> MEM_WB.
- MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEM_WRITE (5): MemWrite=1, IorD=1. Waits for mem_ready, then -> FETCH.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE -> R_WB.
- R_WB (7): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP (9): PCWrite=1, PCSource=10 -> FETCH.
- ADDI_EXEC (10): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD -> ADDI_WB.
- ADDI_WB (11): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- ILLEGAL (14):
  - illegal_op=1; every other output is 0.
  - Sticky: only reset exits.
- Unused encodings 12, 13 -> ILLEGAL on the next edge.
- Cycle counts with mem_ready always 1:
  - lw = 5 cycles; sw = 4; R-type = 4; addi = 4; beq = 3; j = 3.
  - Each wait cycle on mem_ready adds one cycle.
- Mid-operation reset: async return to RST_WAIT from any state. Outputs drop to 0 in the same cycle, so no write (register, memory or PC) completes after reset asserts.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

Optional Feature:
- Macro: MC_ADDI_EN.
- Defined: opcode 001000 decodes to ADDI_EXEC/ADDI_WB as described above.
- Undefined: states 10 and 11 are not implemented, and 001000 decodes to ILLEGAL.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUOp constants (ALUOP_ADD = 3'b000, ALUOP_SUB = 3'b001, ALUOP_RTYPE = 3'b010);
  - ALUSrcB and PCSource selector constants.
- One natural sub-module, mc_ctrl_decode: combinational state -> control-vector decode. The top keeps the state register and the next-state logic.

Test Plan:
- Reset, then release with mem_ready=1 -> state_out sequence F, 0, 1. In cycle FETCH: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp_out=000.
- Opcode=000000, mem_ready=1 -> states 0, 1, 6, 7, 0. In state 6: ALUOp_out=010. In state 7: RegWrite=1, RegDst=1.
- Opcode=100011, mem_ready low for 2 cycles in MEM_READ -> states 0, 1, 2, 3, 3, 3, 4, 0. In state 4: MemtoReg=1, RegWrite=1. Total 7 cycles.
- Opcode=000100 -> BRANCH: ALUOp_out=001, PCWriteCond=1, PCSource=01. Opcode=000010 -> JUMP: PCWrite=1, PCSource=10.
- Opcode=111111 -> ILLEGAL, illegal_op=1 held for 10 cycles; then reset -> RST_WAIT with all outputs 0.
- Opcode=001000: with MC_ADDI_EN -> states 10, 11 with RegWrite=1, RegDst=0; without it -> state 14. Separately, assert reset during MEM_WRITE -> MemWrite drops to 0 the same cycle.
